alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised execute-stage ALU between register manager and write-back.
//  Accepts one op per cycle on a valid/ok handshake and computes move/branch/add-sub/logic/shift.
//  Queues results in a DEPTH-entry buffer. Optional bit-serial shifter trades area for latency.
//  Adds flush, illegal-op reporting and true back-pressure.
// PARAMETERS
//  XLEN          32    datapath width (>=8, power of 2); shamt width SW = $clog2(XLEN)
//  DEPTH         2     result buffer entries (>=2, power of 2)
//  SERIAL_SHIFT  0     1: shifts take 1 cycle per bit; 0: single-cycle barrel shift
//  ALU_UNIT      2'h0  unit code this block owns
// PORTS
//  clk        in   1     clock
//  rst_n      in   1     asynchronous active-low reset
//  valid_i    in   1     op presented this cycle
//  ok_o       out  1     block accepts op (accept = valid_i & ok_o & unit==ALU_UNIT)
//  unit       in   2     functional unit select
//  sub_unit   in   3     0 MOVE, 1 BRANCH, 2 ADDSUB, 3 LOGIC, 4 SHIFT
//  sel        in   4     op within sub_unit
//  rs1, rs2   in   XLEN  operands (rs1 carries pc for MOVE sel1/sel2)
//  immediate  in   XLEN  immediate / precomputed branch target
//  imm        in   1     opb = immediate when 1, else rs2 (BRANCH always compares rs2)
//  rd_i       in   5     destination register
//  flush      in   1     discard everything in flight
//  result_v   out  1     buffer head valid
//  result     out  XLEN  head result
//  rd_o       out  5     head destination (0 for branches and illegal ops)
//  branch     out  1     head is a taken branch
//  illegal    out  1     head op was undefined
//  ok_i       in   1     write-back pops head when result_v & ok_i
// BEHAVIOUR
//  Reset: ok_o=0 during reset, 1 first cycle after; result_v, branch, illegal = 0; result, rd_o = 0.
//  Reset: buffer empty; FSM IDLE.
//  ok_o = FSM==IDLE & !full & !flush; registered terms only, no comb path ok_i->ok_o.
//  MOVE:   sel0 imm; sel1 rs1+imm; sel2 rs1+4; sel3 (rs1+imm)&~1.
//  BRANCH: sel0..5 = EQ,NE,LT,GE,LTU,GEU on rs1 vs rs2.
//  BRANCH: taken -> branch=1, result=immediate; not taken -> branch=0, result=0.
//  ADDSUB: sel0 add, sel1 sub. Results wrap mod 2^XLEN.
//  LOGIC:  sel0 SLT, sel1 SLTU (zero-extended 0/1), sel2 XOR, sel3 OR, sel4 AND.
//  SHIFT:  sel0 SLL, sel1 SRL, sel2 SRA (sign-fill). shamt = opb[SW-1:0]; upper bits ignored.
//  Undefined sub_unit/sel: entry pushed with illegal=1, result=0, rd_o=0, branch=0.
//  Latency (parallel path, or SERIAL_SHIFT=0): accept in cycle N -> result_v in N+1 if buffer empty.
//  Buffer has no bypass.
//  Serial shift FSM, only when SERIAL_SHIFT=1 and op is SHIFT:
//   - IDLE: accept with shamt>0 -> SHIFT; load acc=rs1, cnt=shamt. shamt=0 pushes rs1 directly.
//   - SHIFT: acc shifts 1 bit/cycle, cnt--. cnt==1 -> DONE.
//   - DONE: push acc when !full, then -> IDLE; hold while full.
//   - Latency = shamt+1 cycles (more if full). ok_o=0 outside IDLE.
//  Buffer: circular, wr/rd pointers with extra wrap bit; full = DEPTH entries.
//   - Push and pop in the same cycle are both legal.
//   - Empty: pop ignored. Full: push impossible because ok_o=0; DONE waits.
//  Flush (sync, highest priority):
//   - Clears buffer and aborts FSM to IDLE. Op offered the same cycle is dropped.
//   - result_v=0 next cycle; ok_o=1 the cycle after flush deasserts.
//  Async reset mid-shift or mid-queue: all state cleared immediately, no output glitch after release.
//  Outputs hold steady while result_v & !ok_i.
// STRUCTURE
//  alu_pkg:
//   - sub_unit enum (SU_MOVE..SU_SHIFT) and sel constants per sub_unit.
//   - fsm_t {IDLE,SHIFT,DONE}.
//   - packed struct alu_res_t {branch, illegal, rd, result}.
//  Sub-module alu_result_buffer #(WIDTH=$bits(alu_res_t), DEPTH):
//   - push/pop/flush interface; full/empty outputs.
//  Comb compute and FSM live in alu_pipe.
// TESTING
//  - ADDSUB sel1: rs1=5, rs2=7 -> result=32'hFFFF_FFFE, rd_o=rd_i, result_v one cycle after accept.
//  - BRANCH sel4 (LTU): rs1=1, rs2=32'hFFFF_FFFF, imm=32'h100 -> branch=1, result=32'h100.
//  - BRANCH sel2 (LT), same operands -> branch=0.
//  - SERIAL_SHIFT=1, SRA: rs1=32'h8000_0000, shamt=4 -> result=32'hF800_0000 after 5 cycles;
//    ok_o low for 4 cycles.
//  - ok_i=0, DEPTH=2: two accepts fill buffer -> ok_o=0; one pop -> ok_o=1 next cycle; order preserved.
//  - flush asserted during serial shift with 2 queued -> result_v=0 next cycle, FSM IDLE, no stale result.
//  - sub_unit=3, sel=7 -> illegal=1, rd_o=0; rst_n pulse mid-op -> all outputs 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: sub-unit/select codes, FSM states and the result record.
package alu_pkg;

  localparam int unsigned ALU_XLEN = 32;
  localparam int unsigned RD_W     = 5;

  typedef enum logic [2:0] {
    SU_MOVE   = 3'd0,
    SU_BRANCH = 3'd1,
    SU_ADDSUB = 3'd2,
    SU_LOGIC  = 3'd3,
    SU_SHIFT  = 3'd4
  } sub_unit_e;

  localparam logic [3:0] MV_IMM    = 4'd0;
  localparam logic [3:0] MV_PC_IMM = 4'd1;
  localparam logic [3:0] MV_PC_4   = 4'd2;
  localparam logic [3:0] MV_JALR   = 4'd3;

  localparam logic [3:0] BR_EQ  = 4'd0;
  localparam logic [3:0] BR_NE  = 4'd1;
  localparam logic [3:0] BR_LT  = 4'd2;
  localparam logic [3:0] BR_GE  = 4'd3;
  localparam logic [3:0] BR_LTU = 4'd4;
  localparam logic [3:0] BR_GEU = 4'd5;

  localparam logic [3:0] AS_ADD = 4'd0;
  localparam logic [3:0] AS_SUB = 4'd1;

  localparam logic [3:0] LG_SLT  = 4'd0;
  localparam logic [3:0] LG_SLTU = 4'd1;
  localparam logic [3:0] LG_XOR  = 4'd2;
  localparam logic [3:0] LG_OR   = 4'd3;
  localparam logic [3:0] LG_AND  = 4'd4;

  localparam logic [3:0] SH_SLL = 4'd0;
  localparam logic [3:0] SH_SRL = 4'd1;
  localparam logic [3:0] SH_SRA = 4'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  // Reference layout at the default width; alu_pipe rebuilds the same layout at its XLEN.
  typedef struct packed {
    logic                branch;
    logic                illegal;
    logic [RD_W-1:0]     rd;
    logic [ALU_XLEN-1:0] result;
  } alu_res_t;

endpackage

// File: rtl/alu_result_buffer.sv
// Circular result queue with wrap-bit pointers and a registered head entry.
module alu_result_buffer #(
  parameter int unsigned WIDTH = 39,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             full_nxt_c,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_n, rd_n;
  logic             push_eff, pop_eff, empty_n;
  logic [WIDTH-1:0] head_n;

  always_comb begin
    push_eff = push & ~full;
    pop_eff  = pop & ~empty;
    wr_n     = wr_ptr + PW'(push_eff);
    rd_n     = rd_ptr + PW'(pop_eff);
    if (flush) begin
      wr_n = '0;
      rd_n = '0;
    end
    empty_n    = (wr_n == rd_n);
    full_nxt_c = (wr_n[AW] != rd_n[AW]) && (wr_n[AW-1:0] == rd_n[AW-1:0]);
    // Head reflects storage after this cycle's write, so a push into an empty queue shows next cycle.
    if (empty_n)
      head_n = '0;
    else if (push_eff && (wr_ptr[AW-1:0] == rd_n[AW-1:0]))
      head_n = wdata;
    else
      head_n = mem[rd_n[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push_eff && !flush)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      head   <= '0;
    end else begin
      wr_ptr <= wr_n;
      rd_ptr <= rd_n;
      full   <= full_nxt_c;
      empty  <= empty_n;
      head   <= head_n;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Execute-stage ALU: one op per cycle into a result queue, with optional bit-serial shifter.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DEPTH        = 2,
  parameter bit          SERIAL_SHIFT = 1'b0,
  parameter logic [1:0]  ALU_UNIT     = 2'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ok_o,
  input  logic [1:0]      unit,
  input  logic [2:0]      sub_unit,
  input  logic [3:0]      sel,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] immediate,
  input  logic            imm,
  input  logic [4:0]      rd_i,
  input  logic            flush,
  output logic            result_v,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_o,
  output logic            branch,
  output logic            illegal,
  input  logic            ok_i
);

  localparam int unsigned SW = $clog2(XLEN);

  typedef struct packed {
    logic            branch;
    logic            illegal;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] result;
  } res_t;

  localparam int unsigned RES_W = $bits(res_t);

  function automatic logic [XLEN-1:0] shift1(input logic [XLEN-1:0] v, input logic [1:0] op);
    case (op)
      2'd0:    shift1 = {v[XLEN-2:0], 1'b0};
      2'd1:    shift1 = {1'b0, v[XLEN-1:1]};
      default: shift1 = {v[XLEN-1], v[XLEN-1:1]};
    endcase
  endfunction

  fsm_t            state, state_n;
  logic [XLEN-1:0] acc, acc_n;
  logic [SW-1:0]   cnt, cnt_n;
  logic [1:0]      sh_op, sh_op_n;
  logic [4:0]      sh_rd, sh_rd_n;
  logic            ok_n;

  logic [XLEN-1:0] opb, comb_res, shift_res;
  logic [SW-1:0]   shamt;
  logic            taken, bad_op, accept, serial_go;
  res_t            comb_entry, wdata, head;
  logic            push, buf_full, buf_empty, full_nxt_c;

  // Single-cycle datapath for every sub-unit.
  always_comb begin
    opb      = imm ? immediate : rs2;
    shamt    = opb[SW-1:0];
    comb_res = '0;
    taken    = 1'b0;
    bad_op   = 1'b0;
    if (SERIAL_SHIFT)
      shift_res = rs1;
    else begin
      case (sel)
        SH_SLL:  shift_res = rs1 << shamt;
        SH_SRL:  shift_res = rs1 >> shamt;
        default: shift_res = $unsigned($signed(rs1) >>> shamt);
      endcase
    end
    case (sub_unit)
      SU_MOVE: begin
        case (sel)
          MV_IMM:    comb_res = immediate;
          MV_PC_IMM: comb_res = rs1 + immediate;
          MV_PC_4:   comb_res = rs1 + XLEN'(4);
          MV_JALR:   comb_res = (rs1 + immediate) & ~XLEN'(1);
          default:   bad_op = 1'b1;
        endcase
      end
      SU_BRANCH: begin
        case (sel)
          BR_EQ:   taken = (rs1 == rs2);
          BR_NE:   taken = (rs1 != rs2);
          BR_LT:   taken = ($signed(rs1) < $signed(rs2));
          BR_GE:   taken = ($signed(rs1) >= $signed(rs2));
          BR_LTU:  taken = (rs1 < rs2);
          BR_GEU:  taken = (rs1 >= rs2);
          default: bad_op = 1'b1;
        endcase
        comb_res = taken ? immediate : '0;
      end
      SU_ADDSUB: begin
        case (sel)
          AS_ADD:  comb_res = rs1 + opb;
          AS_SUB:  comb_res = rs1 - opb;
          default: bad_op = 1'b1;
        endcase
      end
      SU_LOGIC: begin
        case (sel)
          LG_SLT:  comb_res = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(opb))};
          LG_SLTU: comb_res = {{(XLEN-1){1'b0}}, (rs1 < opb)};
          LG_XOR:  comb_res = rs1 ^ opb;
          LG_OR:   comb_res = rs1 | opb;
          LG_AND:  comb_res = rs1 & opb;
          default: bad_op = 1'b1;
        endcase
      end
      SU_SHIFT: begin
        if (sel <= SH_SRA)
          comb_res = shift_res;
        else
          bad_op = 1'b1;
      end
      default: bad_op = 1'b1;
    endcase
    if (bad_op)
      comb_res = '0;
    comb_entry.branch  = taken;
    comb_entry.illegal = bad_op;
    comb_entry.rd      = (bad_op || sub_unit == SU_BRANCH) ? '0 : rd_i;
    comb_entry.result  = comb_res;
  end

  assign accept    = valid_i & ok_o & (unit == ALU_UNIT) & ~flush;
  assign serial_go = SERIAL_SHIFT && (sub_unit == SU_SHIFT) && (sel <= SH_SRA) && (shamt != '0);

  // Serial shifter FSM and push arbitration; flush overrides everything.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    sh_op_n = sh_op;
    sh_rd_n = sh_rd;
    push    = 1'b0;
    wdata   = comb_entry;
    case (state)
      IDLE: begin
        if (accept) begin
          if (serial_go) begin
            // First bit moves on the accept edge so total latency is shamt+1.
            acc_n   = shift1(rs1, sel[1:0]);
            cnt_n   = shamt - SW'(1);
            sh_op_n = sel[1:0];
            sh_rd_n = rd_i;
            state_n = (shamt == SW'(1)) ? DONE : SHIFT;
          end else begin
            push = 1'b1;
          end
        end
      end
      SHIFT: begin
        acc_n = shift1(acc, sh_op);
        cnt_n = cnt - SW'(1);
        if (cnt == SW'(1))
          state_n = DONE;
      end
      DONE: begin
        wdata.branch  = 1'b0;
        wdata.illegal = 1'b0;
        wdata.rd      = sh_rd;
        wdata.result  = acc;
        if (!buf_full) begin
          push    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (flush) begin
      state_n = IDLE;
      push    = 1'b0;
    end
    ok_n = (state_n == IDLE) & ~full_nxt_c & ~flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      sh_op <= '0;
      sh_rd <= '0;
      ok_o  <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      sh_op <= sh_op_n;
      sh_rd <= sh_rd_n;
      ok_o  <= ok_n;
    end
  end

  alu_result_buffer #(
    .WIDTH (RES_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (push),
    .wdata      (wdata),
    .pop        (ok_i),
    .full       (buf_full),
    .empty      (buf_empty),
    .full_nxt_c (full_nxt_c),
    .head       (head)
  );

  assign result_v = ~buf_empty;
  assign result   = head.result;
  assign rd_o     = head.rd;
  assign branch   = head.branch;
  assign illegal  = head.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench: a barrel-shift instance (DEPTH 2) and a serial-shift instance (DEPTH 4) share stimulus.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, imm, flush, ok_i;
  logic [1:0]  unit;
  logic [2:0]  sub_unit;
  logic [3:0]  sel;
  logic [31:0] rs1, rs2, immediate;
  logic [4:0]  rd_i;

  logic        p_ok, p_rv, p_br, p_ill;
  logic [31:0] p_res;
  logic [4:0]  p_rd;
  logic        s_ok, s_rv, s_br, s_ill;
  logic [31:0] s_res;
  logic [4:0]  s_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_pipe #(.XLEN(32), .DEPTH(2), .SERIAL_SHIFT(1'b0), .ALU_UNIT(2'h0)) u_par (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ok_o(p_ok), .unit(unit),
    .sub_unit(sub_unit), .sel(sel), .rs1(rs1), .rs2(rs2), .immediate(immediate),
    .imm(imm), .rd_i(rd_i), .flush(flush), .result_v(p_rv), .result(p_res),
    .rd_o(p_rd), .branch(p_br), .illegal(p_ill), .ok_i(ok_i)
  );

  alu_pipe #(.XLEN(32), .DEPTH(4), .SERIAL_SHIFT(1'b1), .ALU_UNIT(2'h0)) u_ser (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ok_o(s_ok), .unit(unit),
    .sub_unit(sub_unit), .sel(sel), .rs1(rs1), .rs2(rs2), .immediate(immediate),
    .imm(imm), .rd_i(rd_i), .flush(flush), .result_v(s_rv), .result(s_res),
    .rd_o(s_rd), .branch(s_br), .illegal(s_ill), .ok_i(ok_i)
  );

  typedef struct {
    string       name;
    logic [2:0]  su;
    logic [3:0]  sel;
    logic [31:0] rs1, rs2, immv;
    logic        use_imm;
    logic [4:0]  rd;
    logic        e_br, e_ill;
    logic [4:0]  e_rd;
    logic [31:0] e_res;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] pk(input logic br, input logic ill, input logic [4:0] rd,
                                     input logic [31:0] r);
    return {25'b0, br, ill, rd, r};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string n, input logic [2:0] su, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] iv,
                         input logic ui, input logic [4:0] rd, input logic br, input logic ill,
                         input logic [4:0] erd, input logic [31:0] eres);
    vec_t v;
    v.name = n; v.su = su; v.sel = s; v.rs1 = a; v.rs2 = b; v.immv = iv; v.use_imm = ui;
    v.rd = rd; v.e_br = br; v.e_ill = ill; v.e_rd = erd; v.e_res = eres;
    vecs.push_back(v);
  endtask

  task automatic drive_op(input logic [2:0] su, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] iv, input logic ui,
                          input logic [4:0] rd);
    sub_unit = su; sel = s; rs1 = a; rs2 = b; immediate = iv; imm = ui; rd_i = rd;
    valid_i = 1'b1;
  endtask

  task automatic wait_both_ok(input string name);
    int n = 0;
    while (!(p_ok && s_ok) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!(p_ok && s_ok)) check({name, "_ok_timeout"}, {62'b0, p_ok, s_ok}, 64'h3);
  endtask

  task automatic run_vec(input vec_t v);
    int n = 0;
    wait_both_ok(v.name);
    drive_op(v.su, v.sel, v.rs1, v.rs2, v.immv, v.use_imm, v.rd);
    @(negedge clk);
    valid_i = 1'b0;
    check({v.name, "_par_lat1"}, {63'b0, p_rv}, 64'h1);
    check({v.name, "_par"}, pk(p_br, p_ill, p_rd, p_res), pk(v.e_br, v.e_ill, v.e_rd, v.e_res));
    while (!s_rv && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({v.name, "_ser"}, {pk(s_br, s_ill, s_rd, s_res) | {24'b0, s_rv, 39'b0}},
          {pk(v.e_br, v.e_ill, v.e_rd, v.e_res) | {24'b0, 1'b1, 39'b0}});
    ok_i = 1'b1;
    @(negedge clk);
    ok_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic seen;
    rst_n = 1'b0; valid_i = 1'b0; imm = 1'b0; flush = 1'b0; ok_i = 1'b0; unit = 2'h0;
    sub_unit = '0; sel = '0; rs1 = '0; rs2 = '0; immediate = '0; rd_i = '0;
    repeat (2) @(negedge clk);
    check("reset_ok", {62'b0, p_ok, s_ok}, 64'h0);
    check("reset_par_out", {pk(p_br, p_ill, p_rd, p_res) | {24'b0, p_rv, 39'b0}}, 64'h0);
    check("reset_ser_out", {pk(s_br, s_ill, s_rd, s_res) | {24'b0, s_rv, 39'b0}}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ok_after_reset", {62'b0, p_ok, s_ok}, 64'h3);

    add_vec("sub_wrap",   3'd2, 4'd1, 32'd5,          32'd7,          32'h0,     1'b0, 5'd3,  1'b0, 1'b0, 5'd3,  32'hFFFF_FFFE);
    add_vec("add_wrap",   3'd2, 4'd0, 32'hFFFF_FFFF,  32'd2,          32'h0,     1'b0, 5'd4,  1'b0, 1'b0, 5'd4,  32'h1);
    add_vec("add_imm",    3'd2, 4'd0, 32'h20,         32'd999,        32'h10,    1'b1, 5'd5,  1'b0, 1'b0, 5'd5,  32'h30);
    add_vec("br_ltu",     3'd1, 4'd4, 32'd1,          32'hFFFF_FFFF,  32'h100,   1'b0, 5'd7,  1'b1, 1'b0, 5'd0,  32'h100);
    add_vec("br_lt",      3'd1, 4'd2, 32'd1,          32'hFFFF_FFFF,  32'h100,   1'b0, 5'd7,  1'b0, 1'b0, 5'd0,  32'h0);
    add_vec("br_eq_imm",  3'd1, 4'd0, 32'h55,         32'h55,         32'h200,   1'b1, 5'd8,  1'b1, 1'b0, 5'd0,  32'h200);
    add_vec("br_geu",     3'd1, 4'd5, 32'd3,          32'd5,          32'h300,   1'b0, 5'd8,  1'b0, 1'b0, 5'd0,  32'h0);
    add_vec("mv_imm",     3'd0, 4'd0, 32'h1234,       32'h0,          32'hABCD,  1'b0, 5'd1,  1'b0, 1'b0, 5'd1,  32'hABCD);
    add_vec("mv_pc_imm",  3'd0, 4'd1, 32'h1000,       32'h0,          32'h24,    1'b0, 5'd2,  1'b0, 1'b0, 5'd2,  32'h1024);
    add_vec("mv_pc_4",    3'd0, 4'd2, 32'h1000,       32'h0,          32'h24,    1'b0, 5'd2,  1'b0, 1'b0, 5'd2,  32'h1004);
    add_vec("mv_jalr",    3'd0, 4'd3, 32'h1001,       32'h0,          32'h4,     1'b0, 5'd6,  1'b0, 1'b0, 5'd6,  32'h1004);
    add_vec("slt",        3'd3, 4'd0, 32'hFFFF_FFFF,  32'd1,          32'h0,     1'b0, 5'd9,  1'b0, 1'b0, 5'd9,  32'h1);
    add_vec("sltu",       3'd3, 4'd1, 32'hFFFF_FFFF,  32'd1,          32'h0,     1'b0, 5'd9,  1'b0, 1'b0, 5'd9,  32'h0);
    add_vec("xor",        3'd3, 4'd2, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0,     1'b0, 5'd10, 1'b0, 1'b0, 5'd10, 32'h0FF0_0FF0);
    add_vec("or",         3'd3, 4'd3, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0,     1'b0, 5'd10, 1'b0, 1'b0, 5'd10, 32'hFFF0_FFF0);
    add_vec("and",        3'd3, 4'd4, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0,     1'b0, 5'd10, 1'b0, 1'b0, 5'd10, 32'hF000_F000);
    add_vec("sll_31",     3'd4, 4'd0, 32'h1,          32'd31,         32'h0,     1'b0, 5'd11, 1'b0, 1'b0, 5'd11, 32'h8000_0000);
    add_vec("srl_hi_ign", 3'd4, 4'd1, 32'h8000_0000,  32'h24,         32'h0,     1'b0, 5'd12, 1'b0, 1'b0, 5'd12, 32'h0800_0000);
    add_vec("sra_imm",    3'd4, 4'd2, 32'h8000_0000,  32'h0,          32'd4,     1'b1, 5'd13, 1'b0, 1'b0, 5'd13, 32'hF800_0000);
    add_vec("sra_zero",   3'd4, 4'd2, 32'h8000_0000,  32'h0,          32'h0,     1'b0, 5'd14, 1'b0, 1'b0, 5'd14, 32'h8000_0000);
    add_vec("srl_one",    3'd4, 4'd1, 32'h6,          32'd1,          32'h0,     1'b0, 5'd15, 1'b0, 1'b0, 5'd15, 32'h3);
    add_vec("ill_logic7", 3'd3, 4'd7, 32'h5,          32'h6,          32'h0,     1'b0, 5'd16, 1'b0, 1'b1, 5'd0,  32'h0);
    add_vec("ill_su6",    3'd6, 4'd0, 32'h5,          32'h6,          32'h0,     1'b0, 5'd17, 1'b0, 1'b1, 5'd0,  32'h0);
    add_vec("ill_shift3", 3'd4, 4'd3, 32'h5,          32'h1,          32'h0,     1'b0, 5'd18, 1'b0, 1'b1, 5'd0,  32'h0);
    add_vec("ill_br6",    3'd1, 4'd6, 32'h5,          32'h5,          32'h40,    1'b0, 5'd19, 1'b0, 1'b1, 5'd0,  32'h0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Serial SRA by 4: ok_o low for four cycles, result on the fifth.
    wait_both_ok("sra_lat");
    drive_op(3'd4, 4'd2, 32'h8000_0000, 32'd4, 32'h0, 1'b0, 5'd20);
    @(negedge clk);
    valid_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("sra_lat_c%0d", i), {62'b0, s_ok, s_rv}, 64'h0);
      @(negedge clk);
    end
    check("sra_lat_c5", {pk(s_br, s_ill, s_rd, s_res) | {24'b0, s_ok, s_rv, 38'b0}},
          {pk(1'b0, 1'b0, 5'd20, 32'hF800_0000) | {24'b0, 2'b11, 38'b0}});
    ok_i = 1'b1;
    @(negedge clk);
    ok_i = 1'b0;

    // Back-pressure on the DEPTH-2 instance: fill, hold, pop one, order preserved.
    drive_op(3'd2, 4'd0, 32'd1, 32'd1, 32'h0, 1'b0, 5'd1);
    @(negedge clk);
    check("bp_first_head", pk(p_br, p_ill, p_rd, p_res) | {24'b0, p_rv, 39'b0},
          pk(1'b0, 1'b0, 5'd1, 32'd2) | {24'b0, 1'b1, 39'b0});
    drive_op(3'd2, 4'd0, 32'd2, 32'd2, 32'h0, 1'b0, 5'd2);
    @(negedge clk);
    valid_i = 1'b0;
    check("bp_full_ok", {63'b0, p_ok}, 64'h0);
    @(negedge clk);
    check("bp_hold", pk(p_br, p_ill, p_rd, p_res) | {24'b0, p_ok, p_rv, 38'b0},
          pk(1'b0, 1'b0, 5'd1, 32'd2) | {24'b0, 2'b01, 38'b0});
    ok_i = 1'b1;
    @(negedge clk);
    ok_i = 1'b0;
    check("bp_pop_ok", {63'b0, p_ok}, 64'h1);
    check("bp_second_head", pk(p_br, p_ill, p_rd, p_res), pk(1'b0, 1'b0, 5'd2, 32'd4));
    check("bp_ser_second", pk(s_br, s_ill, s_rd, s_res), pk(1'b0, 1'b0, 5'd2, 32'd4));
    ok_i = 1'b1;
    @(negedge clk);
    ok_i = 1'b0;
    check("bp_drained", {62'b0, p_rv, s_rv}, 64'h0);

    // Flush mid serial shift with two entries queued.
    drive_op(3'd2, 4'd0, 32'd10, 32'd0, 32'h0, 1'b0, 5'd3);
    @(negedge clk);
    drive_op(3'd2, 4'd0, 32'd11, 32'd0, 32'h0, 1'b0, 5'd4);
    @(negedge clk);
    drive_op(3'd4, 4'd0, 32'h1, 32'd20, 32'h0, 1'b0, 5'd5);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("fl_shifting", {62'b0, s_ok, s_rv}, 64'h1);
    flush = 1'b1;
    drive_op(3'd2, 4'd0, 32'd99, 32'd1, 32'h0, 1'b0, 5'd6);
    @(negedge clk);
    flush = 1'b0;
    valid_i = 1'b0;
    check("fl_rv_cleared", {62'b0, p_rv, s_rv}, 64'h0);
    check("fl_ok_low", {62'b0, p_ok, s_ok}, 64'h0);
    @(negedge clk);
    check("fl_ok_back", {62'b0, p_ok, s_ok}, 64'h3);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      seen |= p_rv | s_rv;
      @(negedge clk);
    end
    check("fl_no_stale", {63'b0, seen}, 64'h0);
    drive_op(3'd2, 4'd0, 32'd7, 32'd8, 32'h0, 1'b0, 5'd7);
    @(negedge clk);
    valid_i = 1'b0;
    check("fl_after_par", pk(p_br, p_ill, p_rd, p_res), pk(1'b0, 1'b0, 5'd7, 32'd15));
    check("fl_after_ser", pk(s_br, s_ill, s_rd, s_res), pk(1'b0, 1'b0, 5'd7, 32'd15));
    ok_i = 1'b1;
    @(negedge clk);
    ok_i = 1'b0;

    // Op for another unit is ignored.
    unit = 2'h1;
    drive_op(3'd2, 4'd0, 32'd1, 32'd1, 32'h0, 1'b0, 5'd8);
    @(negedge clk);
    valid_i = 1'b0;
    unit = 2'h0;
    repeat (2) @(negedge clk);
    check("other_unit", {62'b0, p_rv, s_rv}, 64'h0);

    // Asynchronous reset in the middle of a serial shift and a queued result.
    drive_op(3'd4, 4'd0, 32'h1, 32'd20, 32'h0, 1'b0, 5'd9);
    @(negedge clk);
    valid_i = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_par", {pk(p_br, p_ill, p_rd, p_res) | {24'b0, p_ok, p_rv, 38'b0}}, 64'h0);
    check("arst_ser", {pk(s_br, s_ill, s_rd, s_res) | {24'b0, s_ok, s_rv, 38'b0}}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      seen |= p_rv | s_rv | p_br | s_br | p_ill | s_ill | (|p_res) | (|s_res);
    end
    check("arst_quiet", {63'b0, seen}, 64'h0);
    check("arst_ok", {62'b0, p_ok, s_ok}, 64'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
